// File: rtl/esc_pkg.sv
// ESC array shared definitions: parameter defaults and the
// command-to-pulse-length helper used by every channel.
package esc_pkg;

    localparam int unsigned NUM_CH_DEF      = 4;
    localparam int unsigned PERIOD_W_DEF    = 21;
    localparam int unsigned SPD_W_DEF       = 11;
    localparam int unsigned OFF_W_DEF       = 10;
    localparam int unsigned MIN_PULSE_DEF   = 5000;
    localparam int unsigned SCALE_SHIFT_DEF = 4;

    // Sum is formed one bit wider than either operand, then clamped to
    // the speed range before scaling so calibration cannot overdrive.
    function automatic logic [31:0] pulse_len(
        input logic [31:0] spd,
        input logic [31:0] off,
        input int unsigned spd_w,
        input int unsigned shift,
        input int unsigned min_pulse
    );
        logic [32:0] cmd;
        logic [32:0] sat;
        cmd = {1'b0, spd} + {1'b0, off};
        sat = (33'd1 << spd_w) - 33'd1;
        if (cmd > sat) begin
            cmd = sat;
        end
        return min_pulse + (cmd[31:0] << shift);
    endfunction

endpackage

// File: rtl/esc_pulse_ch.sv
// One ESC channel: active speed/offset registers, pulse-length
// compare against the shared frame counter, and the pwm flop.
module esc_pulse_ch
    import esc_pkg::*;
#(
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
    parameter int unsigned SPD_W       = SPD_W_DEF,
    parameter int unsigned OFF_W       = OFF_W_DEF,
    parameter int unsigned MIN_PULSE   = MIN_PULSE_DEF,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrap,
    input  logic                arm_i,
    input  logic [SPD_W-1:0]    stg_spd,
    input  logic [OFF_W-1:0]    stg_off,
    input  logic [PERIOD_W-1:0] cnt_nxt,
    output logic                pwm
);

    logic [SPD_W-1:0] spd_q, spd_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             pwm_q, pwm_d;
    logic [31:0]      len;

    always_comb begin
        spd_d = spd_q;
        off_d = off_q;
        if (wrap) begin
            spd_d = stg_spd;
            off_d = stg_off;
        end
    end

    always_comb begin
        len = pulse_len(32'(spd_q), 32'(off_q), SPD_W,
                        SCALE_SHIFT, MIN_PULSE);
    end

    // Rise is decided only at the wrap; mid-frame arm changes never cut a pulse.
    always_comb begin
        pwm_d = pwm_q;
        if (wrap) begin
            pwm_d = arm_i;
        end else if (32'(cnt_nxt) == len) begin
            pwm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q <= '0;
            off_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            spd_q <= spd_d;
            off_q <= off_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/esc_array_interface.sv
// Multi-channel ESC pulse generator: shared frame counter, staged
// command updates applied at frame boundaries, per-channel pulse units.
module esc_array_interface
    import esc_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
    parameter int unsigned SPD_W       = SPD_W_DEF,
    parameter int unsigned OFF_W       = OFF_W_DEF,
    parameter int unsigned MIN_PULSE   = MIN_PULSE_DEF,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*SPD_W-1:0] speed,
    input  logic [NUM_CH*OFF_W-1:0] off,
    input  logic                    upd,
    input  logic                    arm,
    output logic [NUM_CH-1:0]       pwm,
    output logic                    frm,
    output logic                    upd_pend
);

    localparam logic [63:0] MAX_LEN =
        64'(MIN_PULSE) + (((64'd1 << SPD_W) - 64'd1) << SCALE_SHIFT);
    localparam logic [63:0] FRAME_LEN = 64'd1 << PERIOD_W;

    // The longest pulse must end before the frame does.
    if (MAX_LEN >= FRAME_LEN) begin : g_bad_cfg
        $error("esc_array_interface: max pulse does not fit in frame");
    end

    logic [PERIOD_W-1:0]     cnt_q, cnt_d;
    logic                    frm_q, frm_d;
    logic                    upd_pend_q, upd_pend_d;
    logic                    armed_q, armed_d;
    logic [NUM_CH*SPD_W-1:0] spd_stg_q, spd_stg_d;
    logic [NUM_CH*OFF_W-1:0] off_stg_q, off_stg_d;
    logic                    wrap;

    assign wrap = &cnt_q;

    always_comb begin
        cnt_d      = cnt_q + PERIOD_W'(1);
        frm_d      = wrap;
        armed_d    = armed_q;
        upd_pend_d = upd_pend_q;
        spd_stg_d  = spd_stg_q;
        off_stg_d  = off_stg_q;
        if (wrap) begin
            armed_d    = arm;
            upd_pend_d = 1'b0;
        end
        // A strobe on the wrap edge wins, so its values wait a frame.
        if (upd) begin
            spd_stg_d  = speed;
            off_stg_d  = off;
            upd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            frm_q      <= 1'b0;
            upd_pend_q <= 1'b0;
            armed_q    <= 1'b0;
            spd_stg_q  <= '0;
            off_stg_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            frm_q      <= frm_d;
            upd_pend_q <= upd_pend_d;
            armed_q    <= armed_d;
            spd_stg_q  <= spd_stg_d;
            off_stg_q  <= off_stg_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pulse_ch #(
            .PERIOD_W   (PERIOD_W),
            .SPD_W      (SPD_W),
            .OFF_W      (OFF_W),
            .MIN_PULSE  (MIN_PULSE),
            .SCALE_SHIFT(SCALE_SHIFT)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .wrap   (wrap),
            .arm_i  (armed_d),
            .stg_spd(spd_stg_q[i*SPD_W +: SPD_W]),
            .stg_off(off_stg_q[i*OFF_W +: OFF_W]),
            .cnt_nxt(cnt_d),
            .pwm    (pwm[i])
        );
    end

    assign frm      = frm_q;
    assign upd_pend = upd_pend_q;

endmodule

// File: tb/tb_esc_array_interface.sv
// Scoreboard bench for esc_array_interface on a shortened frame:
// pulse = 40 + 8*min(speed+off, 31) clocks, frame = 512 clocks.
module tb_esc_array_interface;

    localparam int NCH  = 4;
    localparam int PW   = 9;
    localparam int SW   = 5;
    localparam int OW   = 4;
    localparam int FLEN = 1 << PW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*SW-1:0] speed;
    logic [NCH*OW-1:0] off;
    logic              upd;
    logic              arm;
    logic [NCH-1:0]    pwm;
    logic              frm;
    logic              upd_pend;

    always #5 clk = ~clk;

    esc_array_interface #(
        .NUM_CH     (NCH),
        .PERIOD_W   (PW),
        .SPD_W      (SW),
        .OFF_W      (OW),
        .MIN_PULSE  (40),
        .SCALE_SHIFT(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .speed   (speed),
        .off     (off),
        .upd     (upd),
        .arm     (arm),
        .pwm     (pwm),
        .frm     (frm),
        .upd_pend(upd_pend)
    );

    int checks = 0;
    int errors = 0;

    // Bench-side frame position, reset together with the DUT.
    logic [PW-1:0] tcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else        tcnt <= tcnt + PW'(1);
    end

    typedef struct {
        int   w0, w1, w2, w3;
        int   frms;
        logic pend;
    } exp_t;

    exp_t exp_q[$];
    int   pushed = 0;
    int   popped = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int w0, input int w1, input int w2,
                        input int w3, input int frms, input logic pend);
        exp_t e;
        e.w0 = w0; e.w1 = w1; e.w2 = w2; e.w3 = w3;
        e.frms = frms;
        e.pend = pend;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Monitor: accumulate each frame's pwm/frm shape, compare at frame end.
    int   hi[NCH], rises[NCH], first[NCH];
    logic prev[NCH];
    int   frm_n, frm_first, fidx;

    task automatic clear_acc();
        for (int i = 0; i < NCH; i++) begin
            hi[i] = 0; rises[i] = 0; first[i] = -1; prev[i] = 1'b0;
        end
        frm_n = 0;
        frm_first = -1;
    endtask

    task automatic close_frame();
        exp_t e;
        int   ew[NCH];
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame%0d: no expected record queued", fidx);
        end else begin
            e = exp_q.pop_front();
            popped++;
            ew[0] = e.w0; ew[1] = e.w1; ew[2] = e.w2; ew[3] = e.w3;
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("f%0d ch%0d width", fidx, i), hi[i], ew[i]);
                check($sformatf("f%0d ch%0d rises", fidx, i), rises[i],
                      (ew[i] > 0) ? 1 : 0);
                check($sformatf("f%0d ch%0d start", fidx, i), first[i],
                      (ew[i] > 0) ? 0 : -1);
            end
            check($sformatf("f%0d frm count", fidx), frm_n, e.frms);
            check($sformatf("f%0d frm start", fidx), frm_first,
                  (e.frms > 0) ? 0 : -1);
            check($sformatf("f%0d upd_pend", fidx), int'(upd_pend),
                  int'(e.pend));
        end
        fidx++;
    endtask

    initial begin
        fidx = 0;
        clear_acc();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_acc();
            end else begin
                if (tcnt == '0) clear_acc();
                for (int i = 0; i < NCH; i++) begin
                    if (pwm[i]) begin
                        if (!prev[i]) begin
                            rises[i]++;
                            if (first[i] < 0) first[i] = int'(tcnt);
                        end
                        hi[i]++;
                    end
                    prev[i] = pwm[i];
                end
                if (frm) begin
                    frm_n++;
                    if (frm_first < 0) frm_first = int'(tcnt);
                end
                if (tcnt == PW'(FLEN - 1)) close_frame();
            end
        end
    end

    task automatic wait_at(input int v);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (int'(tcnt) != v && n < 2 * FLEN);
        if (int'(tcnt) != v) begin
            checks++;
            errors++;
            $display("FAIL wait_at: got %0d expected %0d", tcnt, v);
        end
    endtask

    task automatic next_frame();
        wait_at(0);
    endtask

    task automatic set_ch(input int i, input int s, input int o);
        speed[i*SW +: SW] = SW'(s);
        off[i*OW +: OW]   = OW'(o);
    endtask

    task automatic pulse_upd();
        upd = 1'b1;
        @(posedge clk);
        #1;
        upd = 1'b0;
    endtask

    initial begin
        speed = '0;
        off   = '0;
        upd   = 1'b0;
        arm   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset pwm", int'(pwm), 0);
        check("reset frm", int'(frm), 0);
        check("reset upd_pend", int'(upd_pend), 0);
        rst_n = 1'b1;

        // Frame 0: counter starts at 0 but no wrap has happened yet.
        push(0, 0, 0, 0, 0, 1'b0);
        next_frame();
        push(40, 40, 40, 40, 1, 1'b0);
        next_frame();
        push(40, 40, 40, 40, 1, 1'b1);
        wait_at(100);
        set_ch(0, 10, 5);
        pulse_upd();
        speed = '1;
        off   = '1;

        next_frame();
        push(160, 40, 40, 40, 1, 1'b1);
        wait_at(300);
        set_ch(0, 10, 5);
        set_ch(1, 30, 10);
        set_ch(2, 3, 0);
        set_ch(3, 0, 7);
        pulse_upd();
        speed = '1;
        off   = '1;

        next_frame();
        push(160, 288, 64, 96, 1, 1'b0);
        wait_at(50);
        arm = 1'b0;

        next_frame();
        push(0, 0, 0, 0, 1, 1'b0);
        wait_at(200);
        arm = 1'b1;
        wait_at(FLEN - 1);
        set_ch(0, 2, 0);
        set_ch(1, 31, 15);
        set_ch(2, 0, 0);
        set_ch(3, 8, 8);
        pulse_upd();

        // Strobe landed on the wrap edge: this frame keeps old values.
        push(160, 288, 64, 96, 1, 1'b1);
        next_frame();
        push(56, 288, 40, 168, 1, 1'b0);

        next_frame();
        wait_at(10);
        set_ch(0, 31, 15);
        pulse_upd();
        wait_at(20);
        check("pre-reset pwm", int'(pwm), 15);
        check("pre-reset upd_pend", int'(upd_pend), 1);
        rst_n = 1'b0;
        #1;
        check("async reset pwm", int'(pwm), 0);
        check("async reset frm", int'(frm), 0);
        check("async reset upd_pend", int'(upd_pend), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push(0, 0, 0, 0, 0, 1'b0);
        next_frame();
        push(40, 40, 40, 40, 1, 1'b0);
        next_frame();

        check("records consumed", popped, pushed);
        check("queue empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/esc_array_interface.md
ESC_ARRAY_INTERFACE -- requirements
Module: esc_array_interface

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent ESC PWM channels.
REQ-002 Parameter PERIOD_W, default 21: frame counter width; frame length is 2^PERIOD_W clocks.
REQ-003 Parameter SPD_W, default 11: per-channel speed width; parameter OFF_W, default 10: per-channel offset width.
REQ-004 Parameter MIN_PULSE, default 5000: pulse length in clocks at zero command; parameter SCALE_SHIFT, default 4: command-to-clocks left shift.
REQ-005 clk  input  1  single system clock; all state is clocked on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 speed  input  NUM_CH*SPD_W  unsigned speed commands; channel i in bits [i*SPD_W +: SPD_W].
REQ-008 off  input  NUM_CH*OFF_W  unsigned per-channel calibration offsets, same packing.
REQ-009 upd  input  1  one-cycle strobe; captures speed and off into staging registers.
REQ-010 arm  input  1  level; when high, channels emit pulses.
REQ-011 pwm  output  NUM_CH  registered ESC pulse per channel.
REQ-012 frm  output  1  registered one-cycle frame-start marker.
REQ-013 upd_pend  output  1  high while staged values await application.

Function
REQ-014 Frame counter cnt (PERIOD_W bits) shall increment every clock and wrap from 2^PERIOD_W-1 to 0; the wrap edge is the edge on which cnt becomes 0.
REQ-015 Per channel, cmd = speed_i + off_i computed at max(SPD_W,OFF_W)+1 bits, then saturated to 2^SPD_W-1.
REQ-016 pulse_len_i = MIN_PULSE + (cmd << SCALE_SHIFT); defaults give range 5000..37752 clocks.
REQ-017 On upd high, staging registers shall load speed/off and upd_pend shall be set on that edge.
REQ-018 On the wrap edge, active registers shall load from staging, upd_pend shall clear, and armed shall load arm.
REQ-019 upd on the wrap edge itself: capture into staging only, upd_pend stays set, values apply at the following wrap.
REQ-020 On the wrap edge, pwm[i] shall rise iff arm is high on that edge (using the newly loaded active values).
REQ-021 pwm[i] shall fall on the edge on which cnt becomes pulse_len_i; high time is exactly pulse_len_i clocks.
REQ-022 Deasserting arm mid-frame shall not truncate an active pulse; effect applies at the next wrap edge.
REQ-023 frm shall be high for exactly the one cycle in which cnt==0, independent of arm.
REQ-024 Changes to speed/off without upd shall never affect pwm.
REQ-025 Elaboration shall fail if MIN_PULSE + ((2^SPD_W-1) << SCALE_SHIFT) >= 2^PERIOD_W.

Reset
REQ-026 While rst_n low: cnt=0, pwm=0, frm=0, upd_pend=0, armed=0, staging and active registers=0.
REQ-027 Reset asserted mid-pulse shall drive pwm low asynchronously; after release the first pulse occurs at the first wrap edge.
REQ-028 After reset release with no upd, an armed channel shall output pulse_len=MIN_PULSE.

Structure
REQ-029 Package esc_pkg shall hold parameter defaults and a pulse-length function (saturate, shift, add).
REQ-030 Sub-module esc_pulse_ch shall hold one channel's active registers, pulse-length compare, and pwm flop, instantiated NUM_CH times via generate.
REQ-031 Top level shall own the frame counter, frm, arm sampling, staging registers, and upd_pend.

Verification
REQ-032 Reset, arm=1, no upd -> every channel pwm high 5000 clocks starting at cnt==0 each frame; frm coincident with the rise.
REQ-033 Channel 0 speed=100, off=20, upd mid-frame -> current frame unchanged; next frame pulse 5000+120*16=6920 clocks; upd_pend high until that wrap.
REQ-034 Channel 1 speed=2000, off=100 -> cmd saturates at 2047; pulse 37752 clocks.
REQ-035 arm dropped at cnt=1000 during a 6920-clock pulse -> pulse ends at cnt=6920; no pulse next frame; frm still toggles.
REQ-036 upd coincident with wrap edge -> new values apply one frame later; channels with different commands in the same frame show independent widths.
REQ-037 rst_n low at cnt=3000 mid-pulse -> pwm low immediately; after release, no pulse until the first wrap, then 5000-clock pulse.
